// File: rtl/z80db_pkg.sv
// Shared types and constants for the Z80 ROM-window cache loader.
package z80db_pkg;

  localparam int IMG_BYTES_MAX = 16384;
  localparam int SRAM_AW       = 14;
  localparam int DATA_W        = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_ACK,
    ST_WAIT_BYTE,
    ST_SETUP,
    ST_WE,
    ST_HOLD,
    ST_RELEASE,
    ST_RST,
    ST_DONE,
    ST_ERR
  } ld_state_t;

endpackage

// File: rtl/z80_busak_sync.sv
// Two-flop synchroniser bringing the asynchronous Z80 BUSACK into the clk domain.
module z80_busak_sync (
  input  logic clk,
  input  logic reset,
  input  logic busak_n,
  output logic busak_sync
);

  logic busak_n_p0;
  logic busak_n_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      busak_n_p0 <= 1'b1;
      busak_n_p1 <= 1'b1;
    end else begin
      busak_n_p0 <= busak_n;
      // second stage resolves metastability from the first
      busak_n_p1 <= busak_n_p0;
    end
  end

  assign busak_sync = busak_n_p1;

endmodule

// File: rtl/z80_cache_loader.sv
// Streams a ROM image into the cache SRAM while holding the Z80 bus, then optionally resets the CPU.
module z80_cache_loader
  import z80db_pkg::*;
#(
  parameter int IMG_BYTES   = 16384,
  parameter int SETUP_CYC   = 1,
  parameter int WE_CYC      = 2,
  parameter int HOLD_CYC    = 1,
  parameter int ACK_TIMEOUT = 65535,
  parameter int RST_CYC     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                bank,
  input  logic                do_reset,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                busrq_n,
  input  logic                busak_n,
  output logic                cpu_reset_n,
  output logic [SRAM_AW-1:0]  sram_a,
  output logic [DATA_W-1:0]   sram_d,
  output logic                sram_d_oe,
  output logic                sram_ce_n,
  output logic                sram_we_n,
  output logic                sram_oe_n,
  output logic                sram_a14,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CNT_W = 17;
  localparam logic [CNT_W-1:0]   ACK_LAST   = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0]   SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0]   WE_LAST    = CNT_W'(WE_CYC - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]   RST_LAST   = CNT_W'(RST_CYC - 1);
  localparam logic [SRAM_AW-1:0] ADDR_LAST  = SRAM_AW'(IMG_BYTES - 1);

  ld_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             do_reset_q;
  logic             busak_sync;

  z80_busak_sync u_busak_sync (
    .clk        (clk),
    .reset      (reset),
    .busak_n    (busak_n),
    .busak_sync (busak_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      do_reset_q  <= 1'b0;
      busrq_n     <= 1'b1;
      cpu_reset_n <= 1'b1;
      sram_ce_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_d_oe   <= 1'b0;
      sram_a      <= '0;
      sram_d      <= '0;
      sram_a14    <= 1'b0;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state      <= ST_REQ;
            busrq_n    <= 1'b0;
            sram_a     <= '0;
            sram_a14   <= bank;
            do_reset_q <= do_reset;
            done       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b1;
            cnt        <= '0;
          end
        end
        ST_REQ: begin
          state <= ST_WAIT_ACK;
          cnt   <= '0;
        end
        // BUSACK is only looked at here; once granted the Z80 cannot take it back
        ST_WAIT_ACK: begin
          if (!busak_sync) begin
            state     <= ST_WAIT_BYTE;
            s_ready   <= 1'b1;
            sram_ce_n <= 1'b0;
            sram_d_oe <= 1'b0;
          end else if (cnt == ACK_LAST) begin
            state   <= ST_ERR;
            busrq_n <= 1'b1;
            err     <= 1'b1;
            busy    <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WAIT_BYTE: begin
          if (s_valid && s_ready) begin
            state     <= ST_SETUP;
            sram_d    <= s_data;
            sram_d_oe <= 1'b1;
            s_ready   <= 1'b0;
            cnt       <= '0;
          end
        end
        ST_SETUP: begin
          if (cnt == SETUP_LAST) begin
            state     <= ST_WE;
            sram_we_n <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WE: begin
          if (cnt == WE_LAST) begin
            state     <= ST_HOLD;
            sram_we_n <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // address and data stay put through HOLD, so the increment happens on exit
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt       <= '0;
            sram_d_oe <= 1'b0;
            if (sram_a == ADDR_LAST) begin
              state     <= ST_RELEASE;
              sram_ce_n <= 1'b1;
              busrq_n   <= 1'b1;
            end else begin
              state   <= ST_WAIT_BYTE;
              sram_a  <= sram_a + SRAM_AW'(1);
              s_ready <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          cnt <= '0;
          if (do_reset_q) begin
            state       <= ST_RST;
            cpu_reset_n <= 1'b0;
          end else begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_RST: begin
          if (cnt == RST_LAST) begin
            state       <= ST_DONE;
            cpu_reset_n <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_cache_loader.sv
// Scoreboard bench for z80_cache_loader: table of load scenarios plus reset/start corner sequences.
module tb_z80_cache_loader;

  localparam int IMG    = 16;
  localparam int ACK_TO = 100;
  localparam int RSTC   = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        bank = 1'b0;
  logic        do_reset = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        busak_n = 1'b1;
  logic        s_ready, busrq_n, cpu_reset_n, sram_d_oe, sram_ce_n, sram_we_n, sram_oe_n;
  logic        sram_a14, busy, done, err;
  logic [13:0] sram_a;
  logic [7:0]  sram_d;

  always #5 clk = ~clk;

  z80_cache_loader #(
    .IMG_BYTES   (IMG),
    .SETUP_CYC   (1),
    .WE_CYC      (2),
    .HOLD_CYC    (1),
    .ACK_TIMEOUT (ACK_TO),
    .RST_CYC     (RSTC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bank        (bank),
    .do_reset    (do_reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .busrq_n     (busrq_n),
    .busak_n     (busak_n),
    .cpu_reset_n (cpu_reset_n),
    .sram_a      (sram_a),
    .sram_d      (sram_d),
    .sram_d_oe   (sram_d_oe),
    .sram_ce_n   (sram_ce_n),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n),
    .sram_a14    (sram_a14),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  typedef struct packed {
    logic       a14;
    logic [13:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    int bank;
    int do_rst;
    int ack_dly;
    int gaps;
    int rnd_data;
    int mid_start;
    int exp_done;
    int exp_err;
    int exp_writes;
    int exp_rst_low;
  } row_t;

  wr_t         sb[$];
  wr_t         e_wr;
  logic [7:0]  mem [0:32767];
  int          exp_addr = 0;
  int          writes = 0;
  int          rst_low = 0;
  int          viol = 0;
  int          we_len = 0;
  int          ack_delay = -1;
  int          ack_cnt = 0;
  logic        cur_bank = 1'b0;
  logic        prev_we = 1'b1;
  logic [13:0] cap_a;
  logic [7:0]  cap_d;
  row_t        tbl[4];

  // BUSACK responder: grants ack_delay cycles after BUSRQ, never when ack_delay < 0
  initial begin
    forever begin
      @(negedge clk);
      if (busrq_n) begin
        ack_cnt = 0;
        busak_n = 1'b1;
      end else begin
        if (ack_delay >= 0 && ack_cnt >= ack_delay) busak_n = 1'b0;
        ack_cnt++;
      end
    end
  end

  // Stream/SRAM monitor: pushes accepted bytes, pops and checks completed writes
  initial begin
    forever begin
      @(negedge clk);
      if (!sram_we_n && (!sram_d_oe || sram_ce_n)) viol++;
      if (s_valid && s_ready) begin
        sb.push_back({cur_bank, exp_addr[13:0], s_data});
        exp_addr++;
      end
      if (!cpu_reset_n) rst_low++;
      if (!sram_we_n) begin
        if (prev_we) begin
          cap_a = sram_a;
          cap_d = sram_d;
        end
        we_len++;
      end else if (!prev_we) begin
        writes++;
        chk("sb_depth", sb.size(), 1);
        chk("we_low_len", we_len, 2);
        chk("addr_stable", int'(sram_a), int'(cap_a));
        chk("data_stable", int'(sram_d), int'(cap_d));
        if (sb.size() > 0) begin
          e_wr = sb.pop_front();
          chk("wr_addr", int'(sram_a), int'(e_wr.a));
          chk("wr_data", int'(sram_d), int'(e_wr.d));
          chk("wr_bank", int'(sram_a14), int'(e_wr.a14));
        end
        mem[{sram_a14, sram_a}] = sram_d;
        we_len = 0;
      end
      prev_we = sram_we_n;
    end
  end

  task automatic pulse_start(input logic b, input logic dr);
    @(posedge clk); #1;
    start = 1'b1;
    bank = b;
    do_reset = dr;
    cur_bank = b;
    exp_addr = 0;
    writes = 0;
    rst_low = 0;
    viol = 0;
    sb.delete();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int cyc;
    bit hs;
    hs = 1'b0;
    cyc = 0;
    s_data = b;
    s_valid = 1'b1;
    while (!hs && cyc < 200) begin
      @(negedge clk);
      hs = s_ready;
      if (!hs) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("byte_accept", hs, 1);
    if (hs) begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    ok = hs;
  endtask

  task automatic run_load(input row_t r);
    int cyc;
    bit ok;
    ack_delay = r.ack_dly;
    pulse_start(r.bank[0], r.do_rst[0]);
    chk("start_busy", busy, 1);
    chk("start_clr_done", done, 0);
    chk("start_clr_err", err, 0);
    chk("start_busrq", busrq_n, 0);
    if (r.exp_err == 0) begin
      for (int i = 0; i < IMG; i++) begin
        if (r.gaps != 0) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
        send_byte((r.rnd_data != 0) ? 8'($urandom) : 8'(i), ok);
        if (!ok) break;
        if (r.mid_start != 0 && i == 7) begin
          start = 1'b1;
          bank = ~bank;
          @(posedge clk); #1;
          start = 1'b0;
          chk("mid_start_busy", busy, 1);
        end
      end
    end
    cyc = 0;
    while (busy && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("load_finishes", busy, 0);
    if (r.exp_err != 0) chk("ack_timeout_cycles", int'(cyc >= 100 && cyc <= 104), 1);
    chk("done", done, r.exp_done);
    chk("err", err, r.exp_err);
    chk("writes", writes, r.exp_writes);
    chk("cpu_reset_low_cycles", rst_low, r.exp_rst_low);
    chk("end_busrq_n", busrq_n, 1);
    chk("end_cpu_reset_n", cpu_reset_n, 1);
    chk("end_ce_n", sram_ce_n, 1);
    chk("end_d_oe", sram_d_oe, 0);
    chk("end_s_ready", s_ready, 0);
    chk("sb_empty", sb.size(), 0);
    chk("strobe_violations", viol, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  cyc;
    bit  ok;
    //        bank rst ack gap rnd mid done err wr  rstlow
    tbl[0] = '{1, 1,  3,  0,  0,  0,  1,   0,  IMG, RSTC};
    tbl[1] = '{0, 0,  0,  1,  1,  0,  1,   0,  IMG, 0};
    tbl[2] = '{1, 0,  -1, 0,  0,  0,  0,   1,  0,   0};
    tbl[3] = '{0, 1,  5,  1,  1,  1,  1,   0,  IMG, RSTC};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busrq_n", busrq_n, 1);
    chk("rst_cpu_reset_n", cpu_reset_n, 1);
    chk("rst_ce_n", sram_ce_n, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_d_oe", sram_d_oe, 0);
    chk("rst_a", int'(sram_a), 0);
    chk("rst_d", int'(sram_d), 0);
    chk("rst_a14", sram_a14, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;

    for (int t = 0; t < 4; t++) begin
      run_load(tbl[t]);
      if (t == 0) begin
        for (int i = 0; i < IMG; i++) chk("mem_bank1", int'(mem[16384 + i]), i);
      end
    end

    // reset in the middle of a load, after six bytes have been written
    ack_delay = 2;
    pulse_start(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), ok);
    cyc = 0;
    while (writes < 6 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("pre_reset_writes", writes, 6);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busrq_n", busrq_n, 1);
    chk("midrst_ce_n", sram_ce_n, 1);
    chk("midrst_we_n", sram_we_n, 1);
    chk("midrst_d_oe", sram_d_oe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_a", int'(sram_a), 0);
    reset = 1'b0;
    sb.delete();

    run_load(tbl[0]);
    for (int i = 0; i < IMG; i++) chk("mem_reload", int'(mem[16384 + i]), i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
